syscall_ctrl: RTL and testbench

//  Multi-cycle sequencer for MIPS SYSCALL in the pipelined CPU. Freezes the pipeline on a

---
 rtl/syscall_ctrl.sv | 146 ++++++++++++++
 tb/tb_syscall_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_ctrl.sv
// syscall_ctrl: multi-cycle SYSCALL sequencer (print-int, print-string, exit).
// Ports: clk, rst_n, sys/regv/rega from decode; stall/done/halt to the pipeline;
//   mem_req/mem_addr/mem_gnt/mem_rdata word read port; con_* byte stream;
//   int_* integer stream; err only when SYSCALL_ERR_EN is defined.
module syscall_ctrl #(
    parameter logic [31:0] STR_BASE  = 32'h00400000,
    parameter logic [31:0] STR_LIMIT = 32'h00400400,
    parameter int          MAX_CHARS = 1024
) (
`ifdef SYSCALL_ERR_EN
    output logic        err,
`endif
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys,
    input  logic [31:0] regv,
    input  logic [31:0] rega,
    output logic        stall,
    output logic        done,
    output logic        halt,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        int_valid,
    output logic [31:0] int_data,
    input  logic        int_ready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] INT   = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] EMIT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] HALT  = 3'd6;

    localparam logic [10:0] MAX_C = 11'(MAX_CHARS);

    logic [2:0]  state;
    logic [31:0] arg;
    logic [31:0] ptr;
    logic [10:0] count;
    logic [31:0] word_buf;
    logic [7:0]  cur_byte;
    logic [31:0] ptr_nxt;
    logic [10:0] cnt_nxt;
    logic        is_int;
    logic        is_str;
    logic        is_exit;
    logic        str_end;

    assign is_int  = (regv == 32'd1);
    assign is_exit = (regv == 32'd10);
    assign is_str  = (regv == 32'd4) && (rega > STR_BASE) && (rega < STR_LIMIT);

    assign ptr_nxt = ptr + 32'd1;
    assign cnt_nxt = count + 11'd1;
    assign str_end = (cnt_nxt == MAX_C) || (ptr_nxt == STR_LIMIT);

    always_comb begin
        cur_byte = word_buf[7:0];
        unique case (ptr[1:0])
            2'd0: cur_byte = word_buf[7:0];
            2'd1: cur_byte = word_buf[15:8];
            2'd2: cur_byte = word_buf[23:16];
            2'd3: cur_byte = word_buf[31:24];
        endcase
    end

    // Outputs decode from state only, so ready never feeds back into valid.
    assign stall     = ((state != IDLE) && (state != DONE)) || ((state == IDLE) && sys);
    assign done      = (state == DONE);
    assign halt      = (state == HALT);
    assign mem_req   = (state == FETCH);
    assign mem_addr  = (state == FETCH) ? ptr[31:2] : 30'd0;
    assign int_valid = (state == INT);
    assign int_data  = (state == INT) ? arg : 32'd0;
    assign con_valid = (state == EMIT) && (cur_byte != 8'd0);
    assign con_data  = (state == EMIT) ? cur_byte : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            arg      <= 32'd0;
            ptr      <= 32'd0;
            count    <= 11'd0;
            word_buf <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sys) begin
                        arg   <= rega;
                        ptr   <= rega;
                        count <= 11'd0;
                        if (is_int)       state <= INT;
                        else if (is_str)  state <= FETCH;
                        else if (is_exit) state <= HALT;
                        else              state <= DONE;
                    end
                end
                INT: begin
                    if (int_ready) state <= DONE;
                end
                FETCH: begin
                    if (mem_gnt) state <= WAIT;
                end
                WAIT: begin
                    word_buf <= mem_rdata;
                    state    <= EMIT;
                end
                EMIT: begin
                    if (cur_byte == 8'd0) begin
                        state <= DONE;
                    end else if (con_ready) begin
                        ptr   <= ptr_nxt;
                        count <= cnt_nxt;
                        if (str_end)                   state <= DONE;
                        else if (ptr_nxt[1:0] == 2'd0) state <= FETCH;
                    end
                end
                DONE: state <= IDLE;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSCALL_ERR_EN
    // Sticky: bad service code, string outside the window, or byte-cap truncation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            if ((state == IDLE) && sys && !is_int && !is_str && !is_exit)
                err <= 1'b1;
            if ((state == EMIT) && (cur_byte != 8'd0) && con_ready && (cnt_nxt == MAX_C))
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_syscall_ctrl.sv
// tb_syscall_ctrl: directed bench with a string/int expectation model
// and a per-cycle compare process for syscall_ctrl.
module tb_syscall_ctrl;

    localparam logic [31:0] BASE  = 32'h00400000;
    localparam logic [31:0] LIMIT = 32'h00400400;
    localparam int          MAXC  = 1024;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        sys = 0;
    logic [31:0] regv = 0;
    logic [31:0] rega = 0;
    logic        stall, done, halt, mem_req, con_valid, int_valid;
    logic [29:0] mem_addr;
    logic        mem_gnt = 0;
    logic [31:0] mem_rdata = 0;
    logic [7:0]  con_data;
    logic        con_ready = 0;
    logic [31:0] int_data;
    logic        int_ready = 0;
`ifdef SYSCALL_ERR_EN
    logic        err;
`endif

    syscall_ctrl dut (
`ifdef SYSCALL_ERR_EN
        .err(err),
`endif
        .clk(clk), .rst_n(rst_n), .sys(sys), .regv(regv), .rega(rega),
        .stall(stall), .done(done), .halt(halt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .int_valid(int_valid), .int_data(int_data), .int_ready(int_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  exp_bytes [$];
    logic [29:0] exp_fetch [$];
    logic [31:0] exp_int [$];
    logic [7:0]  got_bytes [$];
    logic [29:0] got_fetch [$];
    logic [31:0] got_int [$];
    logic        busy = 0;
    logic        exp_halt = 0;
    logic        exp_err = 0;
    int          rdy_mode = 0;
    int          rst_epoch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [29:0] a);
        if (a >= 30'h00100000 && a < 30'h00100100)
            return mem[a - 30'h00100000];
        return 32'd0;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] p);
        logic [31:0] w;
        w = word_at(p[31:2]);
        return w[8*p[1:0] +: 8];
    endfunction

    // What a syscall must produce, derived straight from the service rules.
    task automatic build_expect(input logic [31:0] v0, input logic [31:0] a0);
        logic [31:0] p;
        logic [7:0]  b;
        int          n;
        bit          stop;
        if (v0 == 1) begin
            exp_int.push_back(a0);
        end else if (v0 == 4 && a0 > BASE && a0 < LIMIT) begin
            p = a0;
            n = 0;
            stop = 0;
            exp_fetch.push_back(p[31:2]);
            while (!stop) begin
                b = byte_at(p);
                if (b == 8'd0) begin
                    stop = 1;
                end else begin
                    exp_bytes.push_back(b);
                    p = p + 1;
                    n = n + 1;
                    if (n == MAXC) begin
                        stop = 1;
                        exp_err = 1;
                    end else if (p == LIMIT) begin
                        stop = 1;
                    end else if (p[1:0] == 2'd0) begin
                        exp_fetch.push_back(p[31:2]);
                    end
                end
            end
        end else if (v0 == 10) begin
            exp_halt = 1;
        end else begin
            exp_err = 1;
        end
    endtask

    // Environment: ready/grant patterns and read data one cycle after grant.
    initial begin
        bit          tog;
        bit          g_take;
        logic [29:0] g_addr;
        tog = 0;
        g_take = 0;
        g_addr = 0;
        forever begin
            @(posedge clk);
            #1;
            tog = ~tog;
            if (g_take) mem_rdata = word_at(g_addr);
            con_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'b0;
            int_ready = (rdy_mode == 2) ? 1'b0 : (rdy_mode == 1) ? ~tog : 1'b1;
            mem_gnt   = mem_req && ((rdy_mode != 1) || tog);
            g_take    = mem_gnt;
            g_addr    = mem_addr;
        end
    end

    // Compare process: every cycle, away from the clock edge.
    initial begin
        logic       p_cv, p_cr, p_iv, p_ir;
        logic [7:0] p_cd;
        logic [31:0] p_id;
        int         p_ep;
        p_cv = 0; p_cr = 0; p_iv = 0; p_ir = 0; p_cd = 0; p_id = 0; p_ep = -1;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!halt) chk("stall", {31'd0, stall}, {31'd0, busy && !done});
                if (halt) begin
                    chk("halt_stall", {31'd0, stall}, 32'd1);
                    chk("halt_expected", {31'd0, exp_halt}, 32'd1);
                end
                if (p_ep == rst_epoch && p_cv && !p_cr) begin
                    chk("con_hold_valid", {31'd0, con_valid}, 32'd1);
                    chk("con_hold_data", {24'd0, con_data}, {24'd0, p_cd});
                end
                if (p_ep == rst_epoch && p_iv && !p_ir) begin
                    chk("int_hold_valid", {31'd0, int_valid}, 32'd1);
                    chk("int_hold_data", int_data, p_id);
                end
                if (con_valid) begin
                    if (exp_bytes.size() == 0) begin
                        chk("con_unexpected", {24'd0, con_data}, 32'hFFFFFFFF);
                    end else begin
                        chk("con_data", {24'd0, con_data}, {24'd0, exp_bytes[0]});
                        if (con_ready) begin
                            got_bytes.push_back(con_data);
                            void'(exp_bytes.pop_front());
                        end
                    end
                end
                if (int_valid) begin
                    if (exp_int.size() == 0) begin
                        chk("int_unexpected", int_data, 32'hFFFFFFFF);
                    end else begin
                        chk("int_data", int_data, exp_int[0]);
                        if (int_ready) begin
                            got_int.push_back(int_data);
                            void'(exp_int.pop_front());
                        end
                    end
                end
                if (mem_req) begin
                    if (exp_fetch.size() == 0) begin
                        chk("fetch_unexpected", {2'd0, mem_addr}, 32'hFFFFFFFF);
                    end else begin
                        chk("mem_addr", {2'd0, mem_addr}, {2'd0, exp_fetch[0]});
                        if (mem_gnt) begin
                            got_fetch.push_back(mem_addr);
                            void'(exp_fetch.pop_front());
                        end
                    end
                end
                if (done) begin
                    chk("done_bytes_left", exp_bytes.size(), 0);
                    chk("done_int_left", exp_int.size(), 0);
                    chk("done_fetch_left", exp_fetch.size(), 0);
                end
            end
            p_cv = con_valid; p_cr = con_ready; p_cd = con_data;
            p_iv = int_valid; p_ir = int_ready; p_id = int_data;
            p_ep = rst_epoch;
        end
    end

    task automatic run_sys(input logic [31:0] v0, input logic [31:0] a0, input int mode);
        int n;
        got_bytes.delete();
        got_fetch.delete();
        got_int.delete();
        rdy_mode = mode;
        build_expect(v0, a0);
        @(posedge clk);
        #1;
        regv = v0;
        rega = a0;
        sys  = 1;
        busy = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        chk("done_seen", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        sys  = 0;
        busy = 0;
        chk("end_bytes_left", exp_bytes.size(), 0);
`ifdef SYSCALL_ERR_EN
        chk("err", {31'd0, err}, {31'd0, exp_err});
`endif
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halt}, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, {2'd0, mem_addr}, 32'd0);
        chk({tag, "_con_valid"}, {31'd0, con_valid}, 32'd0);
        chk({tag, "_con_data"}, {24'd0, con_data}, 32'd0);
        chk({tag, "_int_valid"}, {31'd0, int_valid}, 32'd0);
        chk({tag, "_int_data"}, int_data, 32'd0);
`ifdef SYSCALL_ERR_EN
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 32'h01010101 * (i % 50 + 33);
        mem[1] = 32'h00216948;
        #12;
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        run_sys(32'd1, 32'hFFFFFFF9, 0);
        chk("int_lit_n", got_int.size(), 1);
        if (got_int.size() > 0) chk("int_lit", got_int[0], 32'hFFFFFFF9);
        #1;
        chk("stall_after_int", {31'd0, stall}, 32'd0);

        run_sys(32'd4, 32'h00400004, 0);
        chk("hi_n", got_bytes.size(), 3);
        if (got_bytes.size() == 3) begin
            chk("hi_b0", {24'd0, got_bytes[0]}, 32'h48);
            chk("hi_b1", {24'd0, got_bytes[1]}, 32'h69);
            chk("hi_b2", {24'd0, got_bytes[2]}, 32'h21);
        end
        chk("hi_fetch_n", got_fetch.size(), 1);
        if (got_fetch.size() > 0) chk("hi_fetch", {2'd0, got_fetch[0]}, 32'h00100001);

        run_sys(32'd4, 32'h00400004, 1);
        chk("hi_tog_n", got_bytes.size(), 3);

        mem[1] = 32'h44434241;
        mem[2] = 32'h00004645;
        run_sys(32'd4, 32'h00400006, 0);
        chk("span_n", got_bytes.size(), 4);
        if (got_bytes.size() == 4) begin
            chk("span_b0", {24'd0, got_bytes[0]}, 32'h43);
            chk("span_b3", {24'd0, got_bytes[3]}, 32'h46);
        end
        chk("span_fetch_n", got_fetch.size(), 2);
        if (got_fetch.size() == 2) begin
            chk("span_fetch0", {2'd0, got_fetch[0]}, 32'h00100001);
            chk("span_fetch1", {2'd0, got_fetch[1]}, 32'h00100002);
        end

        mem[255] = 32'h5A595857;
        run_sys(32'd4, 32'h004003FE, 1);
        chk("limit_n", got_bytes.size(), 2);
        if (got_bytes.size() == 2) chk("limit_b1", {24'd0, got_bytes[1]}, 32'h5A);

        run_sys(32'd4, BASE, 0);
        chk("base_n", got_bytes.size() + got_fetch.size(), 0);
        run_sys(32'd4, LIMIT, 0);
        chk("limit_addr_n", got_bytes.size() + got_fetch.size(), 0);
        run_sys(32'd7, 32'd0, 0);
        chk("v7_n", got_bytes.size() + got_int.size(), 0);

        rdy_mode = 2;
        build_expect(32'd4, 32'h00400006);
        @(posedge clk);
        #1;
        regv = 32'd4;
        rega = 32'h00400006;
        sys  = 1;
        busy = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!con_valid && n < 50);
        chk("mid_emit_seen", {31'd0, con_valid}, 32'd1);
        #2;
        rst_epoch++;
        sys   = 0;
        busy  = 0;
        rst_n = 0;
        #1;
        chk_idle_outputs("mid_rst");
        exp_bytes.delete();
        exp_fetch.delete();
        exp_int.delete();
        exp_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1;

        run_sys(32'd1, 32'd42, 1);
        chk("int42_n", got_int.size(), 1);
        if (got_int.size() > 0) chk("int42", got_int[0], 32'd42);

        rdy_mode = 0;
        build_expect(32'd10, 32'd0);
        @(posedge clk);
        #1;
        regv = 32'd10;
        sys  = 1;
        busy = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!halt && n < 20);
        chk("halt_seen", {31'd0, halt}, 32'd1);
        sys = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("halt_sticky", {31'd0, halt}, 32'd1);
            chk("halt_no_done", {31'd0, done}, 32'd0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
